inst_fetch_align: RTL and testbench

INST_FETCH_ALIGN -- requirements
Module: inst_fetch_align

---
 rtl/inst_fetch_align_pkg.sv | 28 ++
 rtl/inst_fetch_align_hw_queue.sv | 64 ++++++
 rtl/inst_fetch_align.sv | 142 ++++++++++++++
 tb/tb_inst_fetch_align.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_align_pkg.sv
// Shared definitions for the Thumb-2 fetch/align block: FSM encoding,
// 32-bit prefix constants and the default reset PC.
package inst_fetch_align_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int unsigned QDEPTH = 4;

  localparam logic [4:0] PFX32_A = 5'b11101;
  localparam logic [4:0] PFX32_B = 5'b11110;
  localparam logic [4:0] PFX32_C = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT      = 2'd1,
    ST_WAIT_DROP = 2'd2
  } fetch_state_e;

  function automatic logic is_32bit_hw(input logic [15:0] hw);
    return (hw[15:11] == PFX32_A) || (hw[15:11] == PFX32_B) ||
           (hw[15:11] == PFX32_C);
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_align_hw_queue.sv
// Four-entry circular halfword queue: push 0/1/2 at the tail, pop 0/1/2 at
// the head, and expose the two head entries for instruction assembly.
module hw_queue
  import inst_fetch_align_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [1:0]  push_n_i,
  input  logic [15:0] push_hw0_i,
  input  logic [15:0] push_hw1_i,
  input  logic [1:0]  pop_n_i,
  output logic [2:0]  count_o,
  output logic [15:0] head0_o,
  output logic [15:0] head1_o
);

  logic [15:0] mem_q [QDEPTH];
  logic [1:0]  rd_q;
  logic [1:0]  rd_d;
  logic [2:0]  count_q;
  logic [2:0]  count_d;
  logic [1:0]  wr_ptr;
  logic [1:0]  wr_ptr_nx;
  logic [1:0]  rd_ptr_nx;

  assign wr_ptr    = rd_q + count_q[1:0];
  assign wr_ptr_nx = wr_ptr + 2'd1;
  assign rd_ptr_nx = rd_q + 2'd1;

  assign head0_o = mem_q[rd_q];
  assign head1_o = mem_q[rd_ptr_nx];
  assign count_o = count_q;

  // The caller guarantees count - pop + push stays within 0..4.
  always_comb begin
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 3'd0;
    end else begin
      rd_d    = rd_q + pop_n_i;
      count_d = count_q + {1'b0, push_n_i} - {1'b0, pop_n_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 2'd0;
      count_q <= 3'd0;
    end else begin
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (push_n_i != 2'd0) mem_q[wr_ptr] <= push_hw0_i;
      if (push_n_i == 2'd2) mem_q[wr_ptr_nx] <= push_hw1_i;
    end
  end

endmodule

// File: rtl/inst_fetch_align.sv
// Thumb-2 instruction fetch and alignment: fetches words from imem, splits
// them into halfwords and presents 16/32-bit instructions to decode.
module inst_fetch_align
  import inst_fetch_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_is32
);

  logic [2:0]   q_count;
  logic [15:0]  q_head0;
  logic [15:0]  q_head1;
  logic [1:0]   push_n;
  logic [1:0]   pop_n;
  logic [15:0]  push_hw0;
  logic         head_is32;
  logic         hs;
  logic         accept;
  logic         refill;
  logic [2:0]   count_next;
  logic [31:0]  branch_pc;

  fetch_state_e state_q;
  logic         req_q;
  logic [31:0]  addr_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  fetch_pc_d;
  logic [31:0]  head_pc_q;
  logic [31:0]  head_pc_d;

  assign branch_pc  = {branch_target[31:1], 1'b0};
  assign head_is32  = is_32bit_hw(q_head0);
  assign inst_valid = (q_count != 3'd0) && (!head_is32 || (q_count >= 3'd2));
  assign hs         = inst_valid && inst_ready;

  // A redirect flushes the queue, so a same-cycle handshake needs no pop.
  assign pop_n    = (hs && !branch_valid) ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;
  assign accept   = (state_q == ST_WAIT) && imem_ack && !branch_valid;
  assign push_n   = accept ? (fetch_pc_q[1] ? 2'd1 : 2'd2) : 2'd0;
  assign push_hw0 = fetch_pc_q[1] ? imem_rdata[31:16] : imem_rdata[15:0];

  assign count_next = branch_valid ? 3'd0
                                   : q_count + {1'b0, push_n} - {1'b0, pop_n};
  assign refill     = (count_next <= 3'd2);

  hw_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (branch_valid),
    .push_n_i   (push_n),
    .push_hw0_i (push_hw0),
    .push_hw1_i (imem_rdata[31:16]),
    .pop_n_i    (pop_n),
    .count_o    (q_count),
    .head0_o    (q_head0),
    .head1_o    (q_head1)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    if (branch_valid) begin
      fetch_pc_d = branch_pc;
      head_pc_d  = branch_pc;
    end else begin
      if (accept) fetch_pc_d = word_addr(fetch_pc_q) + 32'd4;
      if (hs)     head_pc_d  = head_pc_q + (head_is32 ? 32'd4 : 32'd2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
    end
  end

  // Only one fetch is ever outstanding; WAIT_DROP holds the bus stable until
  // the stale request is acknowledged, then discards its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= word_addr(RESET_PC);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (refill) begin
            state_q <= ST_WAIT;
            req_q   <= 1'b1;
            addr_q  <= word_addr(fetch_pc_d);
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            if (refill) begin
              addr_q <= word_addr(fetch_pc_d);
            end else begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end
          end else if (branch_valid) begin
            state_q <= ST_WAIT_DROP;
          end
        end
        ST_WAIT_DROP: begin
          if (imem_ack) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign inst      = inst_valid ? {q_head0, (head_is32 ? q_head1 : 16'h0000)} : 32'h0;
  assign inst_is32 = inst_valid && head_is32;
  assign inst_pc   = head_pc_q;

endmodule

// File: tb/tb_inst_fetch_align.sv
// Bench for inst_fetch_align: memory responder with programmable ack latency,
// expected-instruction scoreboard, vector table plus corner-case sequences.
module tb_inst_fetch_align;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_is32;

  inst_fetch_align #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_is32     (inst_is32)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is32;
  } exp_t;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic        exp_is32;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[8];
  logic [31:0] mem [logic [31:0]];
  int          n_pass = 0;
  int          n_total = 0;
  int          ack_lat = 1;
  int          wait_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hBF00_BF00;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [31:0] i, input logic [31:0] pc, input logic is32);
    exp_t e;
    e.inst = i;
    e.pc   = pc;
    e.is32 = is32;
    exp_q.push_back(e);
  endtask

  task automatic do_branch(input logic [31:0] t);
    branch_valid  = 1'b1;
    branch_target = t;
    @(posedge clk);
    #1;
    branch_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    inst_ready = 1'b0;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL %s_timeout: %0d instructions still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Memory responder: acknowledges after ack_lat idle cycles of imem_req.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !imem_req) begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt >= ack_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_rd(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Scoreboard: every decode handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_inst: got inst %h at pc %h, required no instruction", inst, inst_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check32("inst", inst, e.inst);
        check32("inst_pc", inst_pc, e.pc);
        check32("inst_is32", {31'b0, inst_is32}, {31'b0, e.is32});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] base;
    rst_n         = 1'b0;
    inst_ready    = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 32'h0;

    vecs[0] = '{32'h0000_1000, 32'hBF00_4408, 32'hBF00_BF00, 32'h4408_0000, 32'h0000_1000, 1'b0};
    vecs[1] = '{32'h0000_1102, 32'hBF00_4408, 32'hBF00_BF00, 32'hBF00_0000, 32'h0000_1102, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'hF000_F841, 32'hBF00_BF00, 32'hF841_F000, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_3002, 32'hE800_1234, 32'h5678_ABCD, 32'hE800_ABCD, 32'h0000_3002, 1'b1};
    vecs[4] = '{32'h0000_4002, 32'hF7FF_0000, 32'h0000_FFFE, 32'hF7FF_FFFE, 32'h0000_4002, 1'b1};
    vecs[5] = '{32'h0000_5000, 32'h0000_E7FF, 32'hBF00_BF00, 32'hE7FF_0000, 32'h0000_5000, 1'b0};
    vecs[6] = '{32'hFFFF_FFFE, 32'hE800_0000, 32'h0000_1111, 32'hE800_1111, 32'hFFFF_FFFE, 1'b1};
    vecs[7] = '{32'h0000_6001, 32'h0000_4770, 32'hBF00_BF00, 32'h4770_0000, 32'h0000_6000, 1'b0};

    mem[32'h0] = 32'hBF00_4408;

    // Reset values and first request.
    tick(3);
    check32("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check32("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check32("rst_inst", inst, 32'h0);
    check32("rst_inst_is32", {31'b0, inst_is32}, 32'd0);
    check32("rst_inst_pc", inst_pc, 32'h0);
    rst_n = 1'b1;
    tick(1);
    check32("first_req", {31'b0, imem_req}, 32'd1);
    check32("first_addr", imem_addr, 32'h0);
    push_exp(32'h4408_0000, 32'h0, 1'b0);
    push_exp(32'hBF00_0000, 32'h2, 1'b0);
    inst_ready = 1'b1;
    drain("two_16bit");

    // Table of redirect targets: first instruction at each.
    for (int i = 0; i < 8; i++) begin
      ack_lat = i % 3;
      base = vecs[i].tgt & ~32'h3;
      mem[base]          = vecs[i].w0;
      mem[base + 32'd4]  = vecs[i].w1;
      push_exp(vecs[i].exp_inst, vecs[i].exp_pc, vecs[i].exp_is32);
      do_branch(vecs[i].tgt);
      inst_ready = 1'b1;
      drain("vector");
    end

    // Decode stall: queue fills, fetching stops, outputs hold.
    ack_lat = 1;
    mem[32'h7000] = 32'h0000_4408;
    do_branch(32'h0000_7000);
    tick(8);
    check32("stall_mid_inst", inst, 32'h4408_0000);
    check32("stall_mid_pc", inst_pc, 32'h0000_7000);
    tick(4);
    check32("stall_req", {31'b0, imem_req}, 32'd0);
    check32("stall_count", {29'b0, dut.u_queue.count_o}, 32'd4);
    check32("stall_valid", {31'b0, inst_valid}, 32'd1);
    check32("stall_inst", inst, 32'h4408_0000);
    check32("stall_pc", inst_pc, 32'h0000_7000);
    check32("stall_is32", {31'b0, inst_is32}, 32'd0);
    push_exp(32'h4408_0000, 32'h0000_7000, 1'b0);
    inst_ready = 1'b1;
    drain("stall");

    // Redirect while a fetch is outstanding: stale data dropped.
    ack_lat = 3;
    mem[32'h8000] = 32'h4444_4444;
    mem[32'h0104] = 32'hBF00_1234;
    do_branch(32'h0000_8000);
    do_branch(32'h0000_0106);
    check32("drop_hold_req", {31'b0, imem_req}, 32'd1);
    check32("drop_hold_addr", imem_addr, 32'h0000_8000);
    push_exp(32'hBF00_0000, 32'h0000_0106, 1'b0);
    inst_ready = 1'b1;
    n = 0;
    while (!(imem_req && imem_addr != 32'h0000_8000) && n < 50) begin
      tick(1);
      n++;
    end
    check32("redirect_req", {31'b0, imem_req}, 32'd1);
    check32("redirect_addr", imem_addr, 32'h0000_0104);
    drain("redirect");

    // Reset in the middle of a request.
    ack_lat = 5;
    mem[32'h0] = 32'hBF00_4408;
    do_branch(32'h0000_9000);
    check32("pre_rst_req", {31'b0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check32("mid_rst_req", {31'b0, imem_req}, 32'd0);
    check32("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
    check32("mid_rst_inst", inst, 32'h0);
    check32("mid_rst_is32", {31'b0, inst_is32}, 32'd0);
    check32("mid_rst_pc", inst_pc, 32'h0);
    tick(2);
    rst_n   = 1'b1;
    ack_lat = 1;
    tick(1);
    check32("restart_req", {31'b0, imem_req}, 32'd1);
    check32("restart_addr", imem_addr, 32'h0);
    push_exp(32'h4408_0000, 32'h0, 1'b0);
    push_exp(32'hBF00_0000, 32'h2, 1'b0);
    inst_ready = 1'b1;
    drain("restart");

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
